// File: rtl/hier_rx_pkg.sv
// hier_rx_pkg -- definitions shared by the serial receiver (hier_rx) and the
// matching transmitter.
//   SYNC_STAGES     : depth of the rx input synchronizer (2 flops).
//   hier_rx_state_t : receiver FSM state encoding.
// Optional feature macro: HIER_RX_PARITY_EN adds the PARITY state.
package hier_rx_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // Encodings are fixed so that the parity build and the plain build
    // agree on the value of every state they have in common.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef HIER_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } hier_rx_state_t;

endpackage

// File: rtl/hier_rx_sync.sv
// hier_rx_sync -- multi-flop synchronizer for the asynchronous rx line.
// Ports:
//   clock   : sole clock
//   reset_n : asynchronous active-low reset; all stages reset to 1 (line idle)
//   d       : asynchronous input
//   q       : synchronized output, STAGES clocks behind d
module hier_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hier_rx.sv
// hier_rx -- asynchronous serial receiver (start, WIDTH data bits LSB first,
// optional even parity bit, stop bit) with a one-word valid/ready output.
// Parameters:
//   WIDTH : data bits per frame (1..16)
//   DIV   : clocks per bit period (even, >= 2)
// Ports:
//   clock      : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rx         : serial line, idle high
//   ready      : consumer accepts data when valid && ready
//   data       : last received word
//   valid      : data holds an unconsumed word
//   frame_err  : one-cycle pulse, stop bit sampled 0 (word discarded)
//   overrun    : one-cycle pulse, completed word dropped (valid && !ready)
//   parity_err : one-cycle pulse coinciding with the delivery of a word whose
//                even parity failed (only with HIER_RX_PARITY_EN)
// Optional feature macro: HIER_RX_PARITY_EN.
module hier_rx
    import hier_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             overrun
`ifdef HIER_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    logic rx_s;

    hier_rx_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              word_done;
`ifdef HIER_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    hier_rx_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Frame FSM: START samples mid-bit, every later sample is one full bit
    // period after the previous one, so all samples land mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
`ifdef HIER_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // LSB arrives first, so shift right and insert at the top.
                    shift_d            = shift_q >> 1;
                    shift_d[WIDTH-1]   = rx_s;
                    bit_d              = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef HIER_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef HIER_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                // Wait out a held-low line so it is not taken as a new start.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output word register: a completed word is taken if the slot is empty
    // or being emptied this same cycle, otherwise it is dropped.
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
`ifdef HIER_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (word_done) begin
            if (!valid_q || ready) begin
                data_d       = shift_q;
                valid_d      = 1'b1;
`ifdef HIER_RX_PARITY_EN
                parity_err_d = par_bad_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef HIER_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef HIER_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef HIER_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_hier_rx.sv
// tb_hier_rx -- directed, table-driven bench for hier_rx (WIDTH=8, DIV=4).
// Honours HIER_RX_PARITY_EN in the same way as the design.
module tb_hier_rx;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DIV      = 4;
    localparam int unsigned IDLE_GAP = 3 * DIV;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             rx;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             frame_err;
    logic             overrun;
`ifdef HIER_RX_PARITY_EN
    logic             parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Event counters maintained by the monitor; tests compare deltas.
    int valid_rises  = 0;
    int valid_cycles = 0;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;
    int perr_cnt     = 0;
    int perr_on_rise = 0;
    logic valid_prev = 1'b0;

    hier_rx #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .ready      (ready),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef HIER_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (valid && !valid_prev) valid_rises++;
        if (valid) valid_cycles++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
`ifdef HIER_RX_PARITY_EN
        if (parity_err) perr_cnt++;
        if (parity_err && valid && !valid_prev) perr_on_rise++;
`endif
        valid_prev = valid;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clock);
    endtask

    // One frame: start, data LSB first, [even parity ^ par_flip], stop,
    // then hold_low extra low clocks, then idle high for IDLE_GAP clocks.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop,
                              input logic par_flip, input int hold_low);
        drive_bit(1'b0);
        for (int i = 0; i < int'(WIDTH); i++) drive_bit(d[i]);
`ifdef HIER_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in plain build");
`endif
        drive_bit(stop);
        rx = 1'b0;
        repeat (hold_low) @(negedge clock);
        rx = 1'b1;
        repeat (IDLE_GAP) @(negedge clock);
    endtask

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             stop;
        int               hold_low;
        logic [WIDTH-1:0] exp_data;
        int               exp_rises;
        int               exp_vcyc;
        int               exp_ferr;
    } vec_t;

    vec_t vecs[5];

    int r0, c0, f0, o0;

    initial begin
        vecs[0] = '{d: 8'hA5, stop: 1'b1, hold_low: 0,  exp_data: 8'hA5, exp_rises: 1, exp_vcyc: 1, exp_ferr: 0};
        vecs[1] = '{d: 8'h00, stop: 1'b1, hold_low: 0,  exp_data: 8'h00, exp_rises: 1, exp_vcyc: 1, exp_ferr: 0};
        vecs[2] = '{d: 8'hFF, stop: 1'b1, hold_low: 0,  exp_data: 8'hFF, exp_rises: 1, exp_vcyc: 1, exp_ferr: 0};
        vecs[3] = '{d: 8'h3C, stop: 1'b0, hold_low: 20, exp_data: 8'hFF, exp_rises: 0, exp_vcyc: 0, exp_ferr: 1};
        vecs[4] = '{d: 8'h81, stop: 1'b1, hold_low: 0,  exp_data: 8'h81, exp_rises: 1, exp_vcyc: 1, exp_ferr: 0};

        reset_n = 1'b0;
        rx      = 1'b1;
        ready   = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_data",      int'(data),      0);
        check("reset_valid",     int'(valid),     0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun",   int'(overrun),   0);
        reset_n = 1'b1;
        repeat (IDLE_GAP) @(negedge clock);

        // Table-driven frames (ready held high).
        foreach (vecs[i]) begin
            r0 = valid_rises; c0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].d, vecs[i].stop, 1'b0, vecs[i].hold_low);
            check($sformatf("vec%0d_data", i),      int'(data),          int'(vecs[i].exp_data));
            check($sformatf("vec%0d_rises", i),     valid_rises - r0,    vecs[i].exp_rises);
            check($sformatf("vec%0d_vcycles", i),   valid_cycles - c0,   vecs[i].exp_vcyc);
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0,       vecs[i].exp_ferr);
            check($sformatf("vec%0d_overrun", i),   ovr_cnt - o0,        0);
        end

        // One-clock glitch while idle: no output activity.
        r0 = valid_rises; f0 = ferr_cnt;
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (IDLE_GAP) @(negedge clock);
        check("glitch_rises",     valid_rises - r0, 0);
        check("glitch_frame_err", ferr_cnt - f0,    0);

        // Overrun: consumer stalled across two words.
        ready = 1'b0;
        r0 = valid_rises; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check("ovr_data",    int'(data),       8'h11);
        check("ovr_valid",   int'(valid),      1);
        check("ovr_rises",   valid_rises - r0, 1);
        check("ovr_pulses",  ovr_cnt - o0,     1);
        ready = 1'b1;
        repeat (2) @(negedge clock);
        check("ovr_drain_valid", int'(valid), 0);
        check("ovr_drain_data",  int'(data),  8'h11);

        // Reset in the middle of data bit 4 of 8'hC3, then a clean 8'h5A.
        r0 = valid_rises; f0 = ferr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        rx = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_valid", int'(valid), 0);
        check("midrst_data",  int'(data),  0);
        reset_n = 1'b1;
        repeat (IDLE_GAP) @(negedge clock);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        check("midrst_rises",     valid_rises - r0, 1);
        check("midrst_new_data",  int'(data),       8'h5A);
        check("midrst_frame_err", ferr_cnt - f0,    0);

`ifdef HIER_RX_PARITY_EN
        // 8'h07 has odd weight; a 0 parity bit is a mismatch.
        r0 = valid_rises;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        check("par_data",      int'(data),       8'h07);
        check("par_rises",     valid_rises - r0, 1);
        check("par_on_rise",   perr_on_rise,     1);
        check("par_pulses",    perr_cnt,         1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hier_rx.md
HIER_RX -- requirements
Module: hier_rx

Interface
- REQ-001: Parameter WIDTH, default 8, data bits per frame (1..16).
- REQ-002: Parameter DIV, default 4, clocks per bit period (even, >=2).
- REQ-003: clock  input  1  sole clock; all state updates on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: rx  input  1  serial line, idle high, driven by the matching serial transmitter block.
- REQ-006: ready  input  1  consumer accepts the word in any cycle where valid and ready are both 1.
- REQ-007: data  output  WIDTH  last received word, LSB received first.
- REQ-008: valid  output  1  data holds an unconsumed word.
- REQ-009: frame_err  output  1  one-cycle pulse, stop bit sampled 0.
- REQ-010: overrun  output  1  one-cycle pulse, completed word dropped because valid=1 and ready=0.
- REQ-011: parity_err  output  1  one-cycle pulse, even-parity mismatch; present only under HIER_RX_PARITY_EN.

Function
- REQ-012: rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
- REQ-013: FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
- REQ-014: IDLE -> START when rx_s=0; bit counter and sample counter cleared.
- REQ-015: START SHALL wait DIV/2 cycles, then sample rx_s: 0 -> DATA, 1 -> IDLE (glitch, no output activity).
- REQ-016: DATA SHALL sample rx_s every DIV cycles into the shift register, LSB first, WIDTH samples total.
- REQ-017: After the last data sample, the FSM SHALL go to PARITY if HIER_RX_PARITY_EN is defined, else to STOP.
- REQ-018: PARITY SHALL sample one bit after DIV cycles; parity_err pulses if XOR of data bits and parity bit is 1.
- REQ-019: STOP SHALL sample after DIV cycles: rx_s=1 -> word complete, go IDLE; rx_s=0 -> frame_err pulse, word discarded, go BREAK.
- REQ-020: BREAK -> IDLE only when rx_s=1.
- REQ-021: On word complete with valid=0, or valid=1 and ready=1 in the same cycle, data SHALL load and valid SHALL be 1 the next cycle.
- REQ-022: On word complete with valid=1 and ready=0, data and valid SHALL be unchanged and overrun SHALL pulse.
- REQ-023: With no word complete, valid&ready SHALL clear valid next cycle; data SHALL hold its value.
- REQ-024: A word with a parity error SHALL still be delivered; parity_err and the valid rise coincide.
- REQ-025: Latency from the stop-bit sample to valid=1 SHALL be one cycle; rx edge to FSM reaction SHALL be two cycles, due to the synchronizer.
- REQ-026: The sample counter SHALL be ceil(log2(DIV)) bits and wrap to 0 at DIV-1. The bit counter SHALL be ceil(log2(WIDTH+1)) bits.

Reset
- REQ-027: While reset_n=0: state=IDLE, synchronizer flops=1, counters=0, shift register=0, data=0, valid=0, frame_err=0, overrun=0, parity_err=0.
- REQ-028: Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a fresh falling edge of rx_s.

Configuration
- REQ-029: Macro HIER_RX_PARITY_EN defined: PARITY state, parity_err port and check exist; frame = start + WIDTH + parity + stop.
- REQ-030: Macro undefined: no PARITY state, no parity_err port; frame = start + WIDTH + stop.

Structure
- REQ-031: The FSM state encoding and the sync-stage constant (2) SHALL live in shared package hier_rx_pkg, also used by the transmitter.
- REQ-032: The synchronizer SHALL be a sub-module named hier_rx_sync; all other logic stays in hier_rx.

Verification
- REQ-033: WIDTH=8, DIV=4, ready=1, send 8'hA5 with a valid stop bit -> data=8'hA5, valid high for exactly one cycle, no error pulses.
- REQ-034: rx low for 1 clock only while IDLE -> FSM returns to IDLE, valid/frame_err stay 0.
- REQ-035: Send 8'h3C with stop bit 0, then hold rx low 20 clocks -> frame_err pulses once, valid stays 0, next frame is received only after rx returns high.
- REQ-036: ready=0, send 8'h11 then 8'h22 -> data=8'h11, valid=1, overrun pulses at the second word's completion; then ready=1 -> valid drops.
- REQ-037: Assert reset_n=0 during data bit 4 of a frame, release, send 8'h5A -> only 8'h5A is delivered.
- REQ-038: With HIER_RX_PARITY_EN, send 8'h07 with parity bit 0 -> data=8'h07, valid=1 and parity_err=1 in the same cycle.
